// File: rtl/clint_axil_mst_pkg.sv
// Shared CLINT AXI4-Lite definitions: bus width macros, master FSM states and AXI response codes.
`ifndef CLINT_AXI_ADDR_WIDTH
`define CLINT_AXI_ADDR_WIDTH 32
`endif
`ifndef CLINT_AXI_DATA_WIDTH
`define CLINT_AXI_DATA_WIDTH 32
`endif

package clint_axil_mst_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WAIT_B,
        S_RD,
        S_WAIT_R,
        S_RSP
    } state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    // SLVERR and DECERR both carry RESP[1]; OKAY and EXOKAY are successful.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/clint_axil_mst.sv
// Single-outstanding AXI4-Lite master bridging a simple core request/response port
// to the CLINT software/timer slave.
`ifndef CLINT_AXI_ADDR_WIDTH
`define CLINT_AXI_ADDR_WIDTH 32
`endif
`ifndef CLINT_AXI_DATA_WIDTH
`define CLINT_AXI_DATA_WIDTH 32
`endif

module clint_axil_mst
    import clint_axil_mst_pkg::*;
#(
    parameter int         ADDR_W = `CLINT_AXI_ADDR_WIDTH,
    parameter int         DATA_W = `CLINT_AXI_DATA_WIDTH,
    parameter logic [2:0] PROT   = 3'b000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    state_t              state, state_nxt;
    logic                aw_done, w_done;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                err_q;
    logic                aw_hs, w_hs, b_hs, r_hs;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_nxt     = state;
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_nxt = req_we_i ? S_WR : S_RD;
            end
            S_WR: begin
                // Each channel drops independently once its own handshake is recorded.
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_nxt = S_RSP;
            end
            S_RD: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nxt = S_WAIT_R;
            end
            S_WAIT_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_nxt = S_RSP;
            end
            S_RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY  && M_AXI_BVALID;
    assign r_hs  = M_AXI_RREADY  && M_AXI_RVALID;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_ready_o && req_valid_i) begin
                addr_q <= req_addr_i;
                if (req_we_i) begin
                    wdata_q <= req_wdata_i;
                    wstrb_q <= req_wstrb_i;
                end
            end
            if (state == S_WR && state_nxt == S_WAIT_B) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (b_hs) begin
                rdata_q <= '0;
                err_q   <= resp_is_err(M_AXI_BRESP);
            end
            if (r_hs) begin
                rdata_q <= M_AXI_RDATA;
                err_q   <= resp_is_err(M_AXI_RRESP);
            end
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = PROT;
    assign M_AXI_ARPROT = PROT;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_err_o    = err_q;

endmodule
